// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for the BCD countdown timer: load/start/pause/tick in,
// BCD count and status flags out.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  expired;
  logic                  done;

  modport master (
    output load, load_value, start, pause, tick,
    input  count, running, expired, done
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output count, running, expired, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down-counter with start/pause/resume, tick-gated
// decrement, one-cycle done pulse on expiry and optional auto-reload.
module bcd_countdown_timer #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                   clock,
  input  logic                   clear_n,
  bcd_countdown_timer_if.slave   bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HOLD    = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_next;
  logic [W-1:0]   r_reload;
  logic [W-1:0]   w_reload_next;
  logic           r_done;
  logic           w_done_next;
  logic [W-1:0]   w_clamped;
  logic [W-1:0]   w_decrement;
  logic [DIGITS-1:0] w_borrow;
  logic           w_is_zero;
  logic           w_is_one;

  // Borrow ripples upward through every digit that currently reads 0.
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_in_digit;
      logic [3:0] w_cur_digit;

      assign w_in_digit  = bus.load_value[4*gi +: 4];
      assign w_cur_digit = r_count[4*gi +: 4];

      assign w_clamped[4*gi +: 4] = (w_in_digit > 4'd9) ? 4'd9 : w_in_digit;

      assign w_decrement[4*gi +: 4] =
        !w_borrow[gi]          ? w_cur_digit :
        (w_cur_digit == 4'd0)  ? 4'd9        :
                                 w_cur_digit - 4'd1;

      if (gi < DIGITS - 1) begin : g_chain
        assign w_borrow[gi+1] = w_borrow[gi] && (w_cur_digit == 4'd0);
      end
    end
  endgenerate

  assign w_is_zero = (r_count == '0);
  assign w_is_one  = (r_count == W'(1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_done   <= w_done_next;
    end
  end

  // Priority: load > pause > start > tick.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_done_next   = 1'b0;

    if (bus.load) begin
      w_count_next  = w_clamped;
      w_reload_next = w_clamped;
      w_state_next  = S_IDLE;
    end else if (bus.pause) begin
      if (r_state == S_RUN) begin
        w_state_next = S_HOLD;
      end
    end else if (bus.start && (r_state == S_IDLE || r_state == S_HOLD)) begin
      if (!w_is_zero) begin
        w_state_next = S_RUN;
      end
    end else if (bus.tick && (r_state == S_RUN)) begin
      if (w_is_one) begin
        w_done_next = 1'b1;
        // A zero reload value would restart an already-expired count.
        if (AUTO_RELOAD && (r_reload != '0)) begin
          w_count_next = r_reload;
        end else begin
          w_count_next = '0;
          w_state_next = S_EXPIRED;
        end
      end else begin
        w_count_next = w_decrement;
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.running = (r_state == S_RUN);
  assign bus.expired = (r_state == S_EXPIRED);
  assign bus.done    = r_done;
endmodule
